// File: rtl/traffic_light_monitor.sv
// Checks the controller's traffic-light code: aspect, dwell time, transition/short/timeout faults, cycle count.
// Latency: 1 cycle, all outputs registered. No backpressure: a sample is taken on every clock.
module traffic_light_monitor #(
  parameter int DWELL_W    = 8,
  parameter int CNT_W      = 16,
  parameter int MIN_YELLOW = 2,
  parameter int MAX_RED    = 200,
  parameter int MAX_YELLOW = 20,
  parameter int MAX_GREEN  = 200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         light,
  input  logic               clr,
  output logic [1:0]         mon_state,
  output logic [DWELL_W-1:0] dwell,
  output logic               err_illegal,
  output logic               err_short,
  output logic               err_timeout,
  output logic [2:0]         err_status,
  output logic [CNT_W-1:0]   cycle_cnt
);

  typedef enum logic [1:0] {
    ASP_RED = 2'b00,
    ASP_YEL = 2'b01,
    ASP_GRN = 2'b10,
    ASP_INV = 2'b11
  } aspect_t;

  localparam logic [DWELL_W-1:0] DWELL_SAT = '1;
  localparam logic [CNT_W-1:0]   CNT_SAT   = '1;

  aspect_t              mon_state_q, mon_state_d;
  aspect_t              light_a;
  logic                 primed_q, primed_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [DWELL_W-1:0]   dwell_limit;
  logic                 err_illegal_q, err_illegal_d;
  logic                 err_short_q, err_short_d;
  logic                 err_timeout_q, err_timeout_d;
  logic [2:0]           err_status_q, err_status_d;
  logic [CNT_W-1:0]     cycle_cnt_q, cycle_cnt_d;
  logic                 legal;

  assign light_a = aspect_t'(light);

  // Invalid code (11) is timed against the red limit.
  always_comb begin
    dwell_limit = DWELL_W'(MAX_RED);
    case (mon_state_q)
      ASP_YEL: dwell_limit = DWELL_W'(MAX_YELLOW);
      ASP_GRN: dwell_limit = DWELL_W'(MAX_GREEN);
      default: dwell_limit = DWELL_W'(MAX_RED);
    endcase
  end

  always_comb begin
    legal = 1'b0;
    case ({mon_state_q, light_a})
      {ASP_RED, ASP_YEL},
      {ASP_YEL, ASP_GRN},
      {ASP_YEL, ASP_RED},
      {ASP_GRN, ASP_YEL},
      {ASP_INV, ASP_RED}: legal = 1'b1;
      default:            legal = 1'b0;
    endcase
  end

  always_comb begin
    primed_d      = primed_q;
    mon_state_d   = mon_state_q;
    dwell_d       = dwell_q;
    err_illegal_d = 1'b0;
    err_short_d   = 1'b0;
    err_timeout_d = 1'b0;
    cycle_cnt_d   = cycle_cnt_q;

    if (!primed_q) begin
      // First sample only establishes the aspect; nothing to check against yet.
      primed_d    = 1'b1;
      mon_state_d = light_a;
      dwell_d     = DWELL_W'(1);
    end else if (light_a == mon_state_q) begin
      if (dwell_q != DWELL_SAT) begin
        dwell_d = dwell_q + DWELL_W'(1);
      end
      err_timeout_d = (dwell_q == dwell_limit);
    end else begin
      mon_state_d   = light_a;
      dwell_d       = DWELL_W'(1);
      err_illegal_d = !legal;
      err_short_d   = (mon_state_q == ASP_YEL) && (dwell_q < DWELL_W'(MIN_YELLOW));
      if ((mon_state_q == ASP_YEL) && (light_a == ASP_RED) && (cycle_cnt_q != CNT_SAT)) begin
        cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      end
    end

    // A fresh error wins over a simultaneous clear.
    err_status_d = (clr ? 3'b000 : err_status_q) | {err_timeout_d, err_short_d, err_illegal_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      primed_q      <= 1'b0;
      mon_state_q   <= ASP_RED;
      dwell_q       <= '0;
      err_illegal_q <= 1'b0;
      err_short_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      err_status_q  <= 3'b000;
      cycle_cnt_q   <= '0;
    end else begin
      primed_q      <= primed_d;
      mon_state_q   <= mon_state_d;
      dwell_q       <= dwell_d;
      err_illegal_q <= err_illegal_d;
      err_short_q   <= err_short_d;
      err_timeout_q <= err_timeout_d;
      err_status_q  <= err_status_d;
      cycle_cnt_q   <= cycle_cnt_d;
    end
  end

  assign mon_state   = mon_state_q;
  assign dwell       = dwell_q;
  assign err_illegal = err_illegal_q;
  assign err_short   = err_short_q;
  assign err_timeout = err_timeout_q;
  assign err_status  = err_status_q;
  assign cycle_cnt   = cycle_cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: scripted scenarios with literal expectations plus random traffic vs. a reference model.
module tb_traffic_light_monitor;

  logic        clk;
  logic        rst;
  logic [1:0]  light;
  logic        clr;
  logic [1:0]  mon_state;
  logic [7:0]  dwell;
  logic        err_illegal;
  logic        err_short;
  logic        err_timeout;
  logic [2:0]  err_status;
  logic [15:0] cycle_cnt;

  int n_checks = 0;
  int n_errors = 0;

  traffic_light_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .light      (light),
    .clr        (clr),
    .mon_state  (mon_state),
    .dwell      (dwell),
    .err_illegal(err_illegal),
    .err_short  (err_short),
    .err_timeout(err_timeout),
    .err_status (err_status),
    .cycle_cnt  (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: aspect, run length and counters tracked as plain integers.
  int m_primed, m_state, m_dwell, m_cnt, m_status;
  int m_ill, m_short, m_to;
  int limit_of[4];
  bit legal_tab[4][4];

  initial begin
    limit_of = '{200, 20, 200, 200};
    foreach (legal_tab[a, b]) legal_tab[a][b] = 1'b0;
    legal_tab[0][1] = 1'b1;
    legal_tab[1][2] = 1'b1;
    legal_tab[1][0] = 1'b1;
    legal_tab[2][1] = 1'b1;
    legal_tab[3][0] = 1'b1;
  end

  always @(posedge clk) begin
    int l;
    l = int'(light);
    m_ill = 0; m_short = 0; m_to = 0;
    if (rst) begin
      m_primed = 0; m_state = 0; m_dwell = 0; m_cnt = 0; m_status = 0;
    end else begin
      if (m_primed == 0) begin
        m_primed = 1; m_state = l; m_dwell = 1;
      end else if (l == m_state) begin
        m_to = (m_dwell + 1 == limit_of[m_state] + 1) ? 1 : 0;
        m_dwell = (m_dwell + 1 > 255) ? 255 : m_dwell + 1;
      end else begin
        m_ill = legal_tab[m_state][l] ? 0 : 1;
        m_short = (m_state == 1 && m_dwell < 2) ? 1 : 0;
        if (m_state == 1 && l == 0 && m_cnt < 65535) m_cnt++;
        m_state = l;
        m_dwell = 1;
      end
      m_status = (clr ? 0 : m_status) | (m_to << 2) | (m_short << 1) | m_ill;
    end
    #1;
    check("mon_state",   mon_state,   m_state);
    check("dwell",       dwell,       m_dwell);
    check("err_illegal", err_illegal, m_ill);
    check("err_short",   err_short,   m_short);
    check("err_timeout", err_timeout, m_to);
    check("err_status",  err_status,  m_status);
    check("cycle_cnt",   cycle_cnt,   m_cnt);
  end

  // Drives one sample; returns after the model compare has run for that edge.
  task automatic step(input logic [1:0] l, input logic c = 1'b0, input logic r = 1'b0);
    @(negedge clk);
    light = l; clr = c; rst = r;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int to_pulses;
    int hold;
    logic [1:0] cur;
    rst = 1'b1; light = 2'b00; clr = 1'b0;

    step(2'b00, 1'b0, 1'b1);
    step(2'b00, 1'b0, 1'b1);
    check("rst_dwell", dwell, 0);
    check("rst_status", err_status, 0);
    repeat (3) step(2'b00);
    check("red3_state", mon_state, 0);
    check("red3_dwell", dwell, 3);
    check("red3_cnt", cycle_cnt, 0);

    repeat (3) step(2'b01);
    repeat (3) step(2'b10);
    repeat (3) step(2'b01);
    step(2'b00);
    check("cycle_cnt_1", cycle_cnt, 1);
    check("cycle_dwell", dwell, 1);
    check("cycle_status", err_status, 0);

    step(2'b00);
    step(2'b10);
    check("r2g_illegal", err_illegal, 1);
    check("r2g_status", err_status, 3'b001);
    check("r2g_state", mon_state, 2'b10);
    step(2'b10, 1'b1);
    check("clr_status", err_status, 0);
    check("r2g_pulse_end", err_illegal, 0);

    repeat (2) step(2'b01);
    step(2'b00);
    check("cycle_cnt_2", cycle_cnt, 2);
    step(2'b00);
    step(2'b01);
    step(2'b10);
    check("short_pulse", err_short, 1);
    check("short_no_ill", err_illegal, 0);
    check("short_status", err_status, 3'b010);

    step(2'b01, 1'b1);
    step(2'b01);
    to_pulses = 0;
    for (int i = 1; i <= 205; i++) begin
      step(2'b10);
      if (err_timeout) to_pulses++;
      if (i == 201) check("timeout_at_201", err_timeout, 1);
    end
    check("timeout_count", to_pulses, 1);
    check("green_dwell", dwell, 205);
    check("timeout_status", err_status, 3'b100);

    step(2'b11, 1'b1);
    check("inv_entry_ill", err_illegal, 1);
    check("clr_vs_new_err", err_status, 3'b001);
    step(2'b11);
    check("inv_hold_ill", err_illegal, 0);
    step(2'b00);
    check("inv2red_ill", err_illegal, 0);
    check("inv2red_short", err_short, 0);

    to_pulses = 0;
    for (int i = 1; i <= 259; i++) begin
      step(2'b00);
      if (err_timeout) to_pulses++;
    end
    check("dwell_saturate", dwell, 255);
    check("sat_timeout_count", to_pulses, 1);

    step(2'b01, 1'b0, 1'b1);
    check("midrst_status", err_status, 0);
    check("midrst_cnt", cycle_cnt, 0);

    cur = 2'b00;
    for (int i = 0; i < 4000; i++) begin
      hold = $urandom_range(0, 99);
      if (hold >= 65) cur = 2'($urandom_range(0, 3));
      step(cur, ($urandom_range(0, 15) == 0), ($urandom_range(0, 149) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
